score_hex_display: RTL
======================

// Module: score_hex_display
// PURPOSE
// - Consumes the 16-bit running score from vga_screen and drives the DE2-115 seven-segment displays.
// - Converts the selected value to BCD with a sequential double-dabble engine (one shift per clock).
// - Tracks the session high score and blanks leading zeros; sits between vga_screen and the HEX pins.
// PARAMETERS
// - DIGITS          5  number of displayed decimal digits (5 covers 0..65535)
// - SEG_ACTIVE_LOW  1  1: segment lit when bit=0 (DE2-115); 0: lit when bit=1
// PORTS
// - CLK         in   1            50 MHz system clock, same clock as vga_screen
// - RESET       in   1            asynchronous, active-high reset
// - score       in   16           current score from vga_screen (returns to 0 on death)
// - show_high   in   1            0: display score; 1: display high_score (quasi-static switch)
// - hex_out     out  DIGITS x 7   segment patterns per digit, [0]=ones, bit order {g,f,e,d,c,b,a}
// - high_score  out  16           largest score seen since reset
// - busy        out  1            1 while a conversion is in flight
// BEHAVIOUR
// - Reset values: all hex_out blank (7'h7F when active-low), high_score=0, busy=0, FSM=IDLE, shadow_vld=0.
// - src = show_high ? high_score : score.
// - FSM states: IDLE, SHIFT, COMMIT.
// - IDLE: if (!shadow_vld || src != shadow), load shadow<=src, bin<=src, bcd<=0, cnt<=0, busy<=1 -> SHIFT.
// - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1; cnt++.
//   After 16 shifts -> COMMIT.
// - COMMIT: register decoded digits into hex_out, set shadow_vld<=1, busy<=0 -> IDLE.
// - Latency: src change sampled in IDLE at cycle t -> hex_out updated at edge t+18.
//   Timing: 1 load + 16 shift + 1 commit.
// - src changes during SHIFT/COMMIT are ignored; re-sampled on return to IDLE.
//   Display lags by at most one conversion. Glitches never appear on hex_out.
// - Leading-zero blanking: digit i is blank if it and all higher digits are 0, except digit 0.
//   Value 0 shows a single "0".
// - Width rules: bcd is 4*DIGITS bits; bin is 16 bits; cnt is 5 bits and saturates only via the FSM.
//   If DIGITS is too small for the value, the top nibbles are truncated (no error flag).
// - high_score: every cycle, if score > high_score then high_score <= score (registered, 1-cycle lag).
//   It is never cleared except by RESET. score dropping to 0 on death leaves it unchanged.
// - Simultaneous events: a high_score update in the same cycle IDLE samples src with show_high=1
//   is seen on the next IDLE pass.
// - RESET asserted mid-SHIFT: conversion aborts immediately and all outputs return to reset values.
//   First IDLE after release forces a conversion (shadow_vld=0), so "0" appears 18 cycles later.
// STRUCTURE
// - Package score_disp_pkg: typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} disp_state_t.
//   Also holds localparams SEG_BLANK and SEG_DIGIT[0:9] (active-high patterns) and BIN_W=16.
// - Sub-module seg7_decoder: combinational nibble+blank -> 7-bit pattern.
//   It applies SEG_ACTIVE_LOW inversion and is instantiated DIGITS times.
// - FSM, double-dabble datapath, shadow compare and high-score register live in the top module.
// TESTING
// - Reset, score=0 -> hex_out all 7'h7F during reset; busy high cycle 1.
//   18 cycles after release: hex_out[0]=7'h40, others 7'h7F.
// - score 0->1234 -> 18 cycles later hex_out[3:0]={7'h79,7'h24,7'h30,7'h19}, hex_out[4]=7'h7F, busy low.
// - score=65535 -> all five digits show 6,5,5,3,5 (7'h02,7'h12,7'h12,7'h30,7'h12, MSD first); high_score=65535.
// - score 57 then 0, show_high toggles 0->1 -> display "0" then "57"; high_score stays 57.
// - score changes 10->20 at cycle 5 of SHIFT -> "10" committed first, then "20" ~18 cycles later.
//   No intermediate pattern appears.
// - RESET pulsed at cycle 8 of SHIFT with score=999 -> outputs blank/zero at once.
//   After release, "999" appears 18 cycles later with high_score=999.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score seven-segment display path.
// Segment patterns here are active-high; polarity is applied in the decoder.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } disp_state_t;

    localparam int BIN_W = 16;

    // Bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Double-dabble pre-shift correction for one BCD nibble
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to seven-segment pattern, with blanking and
// output polarity selection.
module seg7_decoder
    import score_disp_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] pat_s;

    // Pattern lookup; codes above 9 cannot come out of double-dabble but stay dark
    always_comb begin
        pat_s = SEG_BLANK;
        if (blank_i) begin
            pat_s = SEG_BLANK;
        end else if (nibble_i <= 4'd9) begin
            pat_s = SEG_DIGIT[nibble_i];
        end else begin
            pat_s = SEG_BLANK;
        end
        if (SEG_ACTIVE_LOW) begin
            seg_o = ~pat_s;
        end else begin
            seg_o = pat_s;
        end
    end

endmodule

// File: rtl/score_hex_display.sv
// Score / high-score to DE2-115 HEX display driver using a sequential
// double-dabble conversion; hex_out only changes on a completed conversion.
module score_hex_display
    import score_disp_pkg::*;
#(
    parameter int DIGITS         = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [BIN_W-1:0]        score,
    input  logic                    show_high,
    output logic [DIGITS-1:0][6:0]  hex_out,
    output logic [BIN_W-1:0]        high_score,
    output logic                    busy
);

    localparam int         BCD_W     = 4 * DIGITS;
    localparam logic [6:0] BLANK_PIN = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    disp_state_t              state_q, state_d;
    logic [BIN_W-1:0]         shadow_q, shadow_d;
    logic                     shadow_vld_q, shadow_vld_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [DIGITS-1:0][6:0]   hex_q, hex_d;
    logic [BIN_W-1:0]         hs_q, hs_d;
    logic                     busy_q, busy_d;

    logic [BIN_W-1:0]         src_s;
    logic [BCD_W-1:0]         bcd_adj_s;
    logic [DIGITS-1:0]        blank_s;
    logic [DIGITS-1:0][6:0]   seg_s;
    logic                     upper_zero_s;

    assign src_s = show_high ? hs_q : score;

    // Per-nibble add-3 correction ahead of each shift
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
        end
    end

    // Leading-zero blanking: ones digit is never blanked so 0 shows "0"
    always_comb begin
        blank_s      = '0;
        upper_zero_s = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero_s = upper_zero_s && (bcd_q[4*i +: 4] == 4'd0);
            blank_s[i]   = upper_zero_s;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .nibble_i(bcd_q[4*g +: 4]),
            .blank_i (blank_s[g]),
            .seg_o   (seg_s[g])
        );
    end

    // Conversion FSM next-state and datapath
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        hex_d        = hex_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (!shadow_vld_q || (src_s != shadow_q)) begin
                    shadow_d = src_s;
                    bin_d    = src_s;
                    bcd_d    = '0;
                    cnt_d    = 5'd0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = SHIFT;
                end
            end
            COMMIT: begin
                hex_d        = seg_s;
                shadow_vld_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Session high score tracks the raw score regardless of what is shown
    always_comb begin
        if (score > hs_q) begin
            hs_d = score;
        end else begin
            hs_d = hs_q;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= 5'd0;
            hex_q        <= {DIGITS{BLANK_PIN}};
            hs_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            hex_q        <= hex_d;
            hs_q         <= hs_d;
            busy_q       <= busy_d;
        end
    end

    assign hex_out    = hex_q;
    assign high_score = hs_q;
    assign busy       = busy_q;

endmodule
